// File: rtl/pix_pkg.sv
// Shared types for the pixel-pick path: pixel geometry, the FIFO entry
// layout ({last, data}) and the occupancy state encoding.
package pix_pkg;

    localparam int PIX_W   = 16;
    localparam int NUM_PIX = 16;

    typedef struct packed {
        logic             last;
        logic [PIX_W-1:0] data;
    } pix_entry_t;

    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

endpackage

// File: rtl/pix_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy tracking.
// Ports: clk/rst (async high), wr_req/wr_data in, rd_ready in,
// rd_valid/rd_data out (data 0 when empty), wr_en/rd_en out (accepted
// write/pop this cycle), level out (0..DEPTH).
module pix_sync_fifo
    import pix_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       state_q, state_d;

    always_comb begin
        rd_en    = (level_q != '0) && rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the write.
        wr_en    = wr_req && ((level_q != LVL_FULL) || rd_en);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
        level_d  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
        state_d  = state_q;
        case (state_q)
            OCC_EMPTY: begin
                if (wr_en) state_d = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (level_d == LVL_FULL)
                    state_d = OCC_FULL;
                else if (level_d == '0)
                    state_d = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (rd_en && !wr_en) state_d = OCC_PARTIAL;
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
        end
    end

    // Storage is not reset; level gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;

    occ_empty_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == OCC_EMPTY) == (level_q == '0));
    occ_full_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == OCC_FULL) == (level_q == LVL_FULL));

endmodule

// File: rtl/pix_line_fifo.sv
// Line-framed pixel FIFO: tags the last pixel of each NUM_PIX line,
// buffers pixels FWFT, replays over VALID/READY, flags overflow/runt lines.
// Ports: CLK, RST (async high), PUSH/PIXEL_DATA in, OUT_VALID/OUT_READY/
// OUT_DATA/OUT_LAST out stream, LEVEL, OVERFLOW, RUNT, CLR_ERR, LINE_CNT.
module pix_line_fifo
    import pix_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   PUSH,
    input  logic [PIX_W-1:0]       PIXEL_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [PIX_W-1:0]       OUT_DATA,
    output logic                   OUT_LAST,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   OVERFLOW,
    output logic                   RUNT,
    input  logic                   CLR_ERR,
    output logic [15:0]            LINE_CNT
);

    localparam int IDX_W = $clog2(NUM_PIX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIX - 1);

    logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
    logic             overflow_q, overflow_d;
    logic             runt_q, runt_d;
    logic [15:0]      line_cnt_q, line_cnt_d;

    pix_entry_t wr_entry;
    pix_entry_t head;
    logic       wr_en;
    logic       rd_en;
    logic       is_last_pix;
    logic       ovf_set;
    logic       runt_set;

    always_comb begin
        is_last_pix   = (pix_idx_q == IDX_LAST);
        wr_entry.last = is_last_pix;
        wr_entry.data = PIXEL_DATA;
        // Index advances even on dropped pushes so framing survives overflow.
        if (PUSH)
            pix_idx_d = is_last_pix ? '0 : pix_idx_q + IDX_W'(1);
        else
            pix_idx_d = '0;
        ovf_set    = PUSH && !wr_en;
        runt_set   = !PUSH && (pix_idx_q != '0);
        // A set event in the same cycle beats the clear.
        overflow_d = ovf_set  || (overflow_q && !CLR_ERR);
        runt_d     = runt_set || (runt_q && !CLR_ERR);
        line_cnt_d = line_cnt_q + 16'(rd_en && head.last);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pix_idx_q  <= '0;
            overflow_q <= 1'b0;
            runt_q     <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            pix_idx_q  <= pix_idx_d;
            overflow_q <= overflow_d;
            runt_q     <= runt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    pix_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(pix_entry_t))
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_req   (PUSH),
        .wr_data  (wr_entry),
        .rd_ready (OUT_READY),
        .rd_valid (OUT_VALID),
        .rd_data  (head),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .level    (LEVEL)
    );

    assign OUT_DATA = head.data;
    assign OUT_LAST = head.last;
    assign OVERFLOW = overflow_q;
    assign RUNT     = runt_q;
    assign LINE_CNT = line_cnt_q;

endmodule

// File: tb/tb_pix_line_fifo.sv
// Scoreboard bench for pix_line_fifo: directed line/overflow/runt/reset
// vectors; a negedge monitor pops expected {last,data} on each handshake.
module tb_pix_line_fifo;

    localparam int DEPTH = 32;

    logic        CLK;
    logic        RST;
    logic        PUSH;
    logic [15:0] PIXEL_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT_DATA;
    logic        OUT_LAST;
    logic [5:0]  LEVEL;
    logic        OVERFLOW;
    logic        RUNT;
    logic        CLR_ERR;
    logic [15:0] LINE_CNT;

    pix_line_fifo #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PUSH       (PUSH),
        .PIXEL_DATA (PIXEL_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_LAST   (OUT_LAST),
        .LEVEL      (LEVEL),
        .OVERFLOW   (OVERFLOW),
        .RUNT       (RUNT),
        .CLR_ERR    (CLR_ERR),
        .LINE_CNT   (LINE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [16:0] exp_q[$];
    logic [16:0] mon_exp;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever valid & ready
    // hold at the negedge (inputs only change just after posedges).
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got last=%0b data=0x%0h want none",
                         OUT_LAST, OUT_DATA);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({OUT_LAST, OUT_DATA} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL pop_data: got last=%0b data=0x%0h want last=%0b data=0x%0h",
                             OUT_LAST, OUT_DATA, mon_exp[16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_pix(input logic [15:0] d, input logic last,
                            input logic kept);
        PUSH       = 1'b1;
        PIXEL_DATA = d;
        if (kept) exp_q.push_back({last, d});
        tick();
    endtask

    task automatic drain(input string name);
        bit done;
        done      = 1'b0;
        PUSH      = 1'b0;
        OUT_READY = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !OUT_VALID) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(done), 1);
    endtask

    task automatic line16(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            push_pix(base + 16'(i), i == 15, 1'b1);
            if (i == 0) check("valid_after_first_push", 32'(OUT_VALID), 1);
        end
        PUSH = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        PUSH       = 1'b0;
        PIXEL_DATA = '0;
        OUT_READY  = 1'b0;
        CLR_ERR    = 1'b0;
        #2;
        check("rst_valid", 32'(OUT_VALID), 0);
        check("rst_data", 32'(OUT_DATA), 0);
        check("rst_level", 32'(LEVEL), 0);
        check("rst_line_cnt", 32'(LINE_CNT), 0);
        check("rst_flags", 32'({OVERFLOW, RUNT}), 0);
        tick();
        RST = 1'b0;
        tick();

        // One clean line with the consumer always ready.
        OUT_READY = 1'b1;
        line16(16'h0000);
        drain("t1_drain");
        check("t1_line_cnt", 32'(LINE_CNT), 1);
        check("t1_flags", 32'({OVERFLOW, RUNT}), 0);

        // Three lines into a stalled FIFO: third line dropped. The final
        // dropped push coincides with CLR_ERR, and the set must win.
        OUT_READY = 1'b0;
        for (int i = 0; i < 48; i++) begin
            CLR_ERR = (i == 47);
            push_pix(16'(32'h0100 + i), (i % 16) == 15, i < 32);
            if (i == 31) begin
                check("t2_level_full", 32'(LEVEL), 32);
                check("t2_no_ovf_yet", 32'(OVERFLOW), 0);
            end
            if (i == 32) check("t2_ovf_set", 32'(OVERFLOW), 1);
        end
        check("t6_set_beats_clr", 32'(OVERFLOW), 1);
        check("t2_level_hold", 32'(LEVEL), 32);
        PUSH    = 1'b0;
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        check("t6_clr_alone", 32'(OVERFLOW), 0);
        check("t2_runt", 32'(RUNT), 0);

        // Full FIFO with simultaneous push and pop: nothing dropped.
        OUT_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_pix(16'(32'h0200 + i), i == 15, 1'b1);
            if (i < 4) begin
                check("t3_level_32", 32'(LEVEL), 32);
                check("t3_no_ovf", 32'(OVERFLOW), 0);
            end
        end
        PUSH = 1'b0;
        drain("t3_drain");
        check("t3_line_cnt", 32'(LINE_CNT), 4);
        check("t3_ovf", 32'(OVERFLOW), 0);

        // Short burst, gap, full line: runt flagged, last only on full line.
        for (int i = 0; i < 5; i++)
            push_pix(16'(32'h0300 + i), 1'b0, 1'b1);
        PUSH = 1'b0;
        tick();
        check("t4_runt_set", 32'(RUNT), 1);
        for (int i = 0; i < 16; i++)
            push_pix(16'(32'h0310 + i), i == 15, 1'b1);
        PUSH = 1'b0;
        drain("t4_drain");
        check("t4_line_cnt", 32'(LINE_CNT), 5);
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        check("t4_runt_clr", 32'(RUNT), 0);

        // Asynchronous reset mid-line with 10 entries buffered.
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++)
            push_pix(16'(32'h0400 + i), 1'b0, 1'b1);
        PUSH = 1'b0;
        check("t5_level_10", 32'(LEVEL), 10);
        #1;
        RST = 1'b1;
        exp_q.delete();
        #1;
        check("t5_async_valid", 32'(OUT_VALID), 0);
        check("t5_async_data", 32'({OUT_LAST, OUT_DATA}), 0);
        check("t5_async_level", 32'(LEVEL), 0);
        check("t5_async_line_cnt", 32'(LINE_CNT), 0);
        #1;
        RST = 1'b0;
        tick();
        OUT_READY = 1'b1;
        line16(16'h0500);
        drain("t5_drain");
        check("t5_line_cnt", 32'(LINE_CNT), 1);
        check("t5_flags", 32'({OVERFLOW, RUNT}), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
